// File: rtl/dmem_uart.sv
// Data-side memory for the single-cycle MIPS core: word RAM plus a memory-mapped 8N1 UART transmitter.
// Loads are combinational; stores, FIFO pushes/pops and the serializer all advance on the rising edge.
module dmem_uart #(
  parameter int RAM_WORDS    = 64,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        tx,
  output logic        tx_busy
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST   = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    DEPTH       = 3'(FIFO_DEPTH);
  localparam logic [31:0]   TXDATA_ADDR = 32'hFFFF_0000;
  localparam logic [31:0]   STATUS_ADDR = 32'hFFFF_0004;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // ---------------- address decode and RAM ----------------
  logic [31:0]   ram [RAM_WORDS];
  logic [AW-1:0] word_idx;
  logic          sel_ram;
  logic          sel_txdata;
  logic          sel_status;

  assign word_idx   = addr[AW+1:2];
  assign sel_ram    = ~addr[31];
  assign sel_txdata = (addr == TXDATA_ADDR);
  assign sel_status = (addr == STATUS_ADDR);

  always_ff @(posedge clk) begin
    if (memwrite && sel_ram) begin
      ram[word_idx] <= writedata;
    end
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [2:0]    count;
  logic          overflow;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;

  state_t        state;
  state_t        state_n;

  assign full     = (count == DEPTH);
  assign empty    = (count == 3'd0);
  assign pop      = (state == S_IDLE) && !empty;
  assign push_req = memwrite && sel_txdata && !reset;
  // A full FIFO still takes the byte when the head leaves on the same edge.
  assign push     = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= writedata[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= 3'd0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      if (memwrite && sel_status) begin
        overflow <= 1'b0;
      end else if (push_req && !push) begin
        overflow <= 1'b1;
      end
    end
  end

  // ---------------- serializer ----------------
  logic [BW-1:0] baud_cnt;
  logic [BW-1:0] baud_cnt_n;
  logic [2:0]    bit_cnt;
  logic [2:0]    bit_cnt_n;
  logic [7:0]    shreg;
  logic [7:0]    shreg_n;
  logic          tx_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= 3'd0;
      shreg    <= 8'd0;
      tx       <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_cnt  <= bit_cnt_n;
      shreg    <= shreg_n;
      tx       <= tx_n;
    end
  end

  // tx_n is the line level for the next cycle, so tx itself is always a flop output.
  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    tx_n       = tx;
    case (state)
      S_IDLE: begin
        tx_n = 1'b1;
        if (!empty) begin
          state_n    = S_START;
          shreg_n    = fifo_mem[rd_ptr];
          baud_cnt_n = '0;
          tx_n       = 1'b0;
        end
      end
      S_START: begin
        if (baud_cnt == BAUD_LAST) begin
          state_n    = S_DATA;
          baud_cnt_n = '0;
          bit_cnt_n  = 3'd0;
          tx_n       = shreg[0];
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_cnt_n = '0;
          if (bit_cnt == 3'd7) begin
            state_n = S_STOP;
            tx_n    = 1'b1;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
            shreg_n   = {1'b0, shreg[7:1]};
            tx_n      = shreg[1];
          end
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      S_STOP: begin
        tx_n = 1'b1;
        if (baud_cnt == BAUD_LAST) begin
          state_n    = S_IDLE;
          baud_cnt_n = '0;
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  assign tx_busy = !empty || (state != S_IDLE);

  // ---------------- load path ----------------
  always_comb begin
    readdata = 32'd0;
    if (sel_ram) begin
      readdata = ram[word_idx];
    end else if (sel_status) begin
      readdata = {25'd0, count, overflow, (state != S_IDLE), empty, full};
    end
  end

endmodule

// File: tb/tb_dmem_uart.sv
// Bench for dmem_uart: vector table for RAM/decode, hand sequences for UART timing,
// and a frame-decoding monitor checked against a scoreboard of expected bytes.
module tb_dmem_uart;

  localparam int CPB = 16;
  localparam logic [31:0] TXDATA = 32'hFFFF_0000;
  localparam logic [31:0] STATUS = 32'hFFFF_0004;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memwrite = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        tx;
  logic        tx_busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] sb [$];
  int         starts [$];

  dmem_uart #(.RAM_WORDS(64), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .addr      (addr),
    .writedata (writedata),
    .readdata  (readdata),
    .tx        (tx),
    .tx_busy   (tx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // ---------------- UART monitor / scoreboard ----------------
  logic       m_active = 1'b0;
  int         m_cnt = 0;
  int         m_k = 0;
  logic [7:0] m_byte = 8'd0;
  logic [7:0] m_req = 8'd0;

  always @(negedge clk) begin
    if (reset) begin
      if (m_active) begin
        m_active = 1'b0;
        sb.delete();
      end
    end else if (!m_active) begin
      if (tx === 1'b0) begin
        m_active = 1'b1;
        m_cnt = 0;
        starts.push_back(cyc);
      end
    end else begin
      m_cnt++;
      if (m_cnt % CPB == CPB / 2) begin
        m_k = m_cnt / CPB;
        if (m_k == 0) begin
          chk("mon_start_bit", {31'd0, tx}, 32'd0);
        end else if (m_k <= 8) begin
          m_byte[m_k-1] = tx;
        end else begin
          chk("mon_stop_bit", {31'd0, tx}, 32'd1);
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL mon_unexpected_frame actual=0x%02h required=none", m_byte);
          end else begin
            m_req = sb.pop_front();
            chk("mon_byte", {24'd0, m_byte}, {24'd0, m_req});
          end
          m_active = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memwrite  = 1'b1;
    addr      = a;
    writedata = d;
    tick();
    memwrite  = 1'b0;
    writedata = 32'd0;
    addr      = 32'd0;
  endtask

  task automatic txw(input logic [7:0] b, input bit accept);
    wr(TXDATA, {24'd0, b});
    if (accept) sb.push_back(b);
  endtask

  task automatic status_chk(input string name, input logic [31:0] req);
    addr = STATUS;
    #1;
    chk(name, readdata, req);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((tx_busy || m_active) && n < 3000) begin
      tick();
      n++;
    end
    chk({name, "_drain_done"}, {31'd0, (n < 3000)}, 32'd1);
    chk({name, "_sb_empty"}, sb.size(), 32'd0);
  endtask

  task automatic gap_chk(input string name, input int nframes);
    chk({name, "_frames"}, starts.size(), nframes);
    for (int i = 1; i < starts.size(); i++) begin
      chk($sformatf("%s_gap%0d", name, i), starts[i] - starts[i-1], 10 * CPB + 1);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] req;
  } vec_t;

  vec_t vecs [$];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int errs;
    int first_bad;
    logic req_tx;
    int n;

    vecs.push_back('{1'b0, STATUS,         32'h0,        32'h0000_0002});
    vecs.push_back('{1'b0, TXDATA,         32'h0,        32'h0});
    vecs.push_back('{1'b1, 32'h14,         32'hCAFEF00D, 32'h0});
    vecs.push_back('{1'b1, 32'h10,         32'hDEADBEEF, 32'h0});
    vecs.push_back('{1'b1, 32'h08,         32'h11111111, 32'h0});
    vecs.push_back('{1'b0, 32'h10,         32'h0,        32'hDEADBEEF});
    vecs.push_back('{1'b0, 32'h13,         32'h0,        32'hDEADBEEF});
    vecs.push_back('{1'b0, 32'h14,         32'h0,        32'hCAFEF00D});
    vecs.push_back('{1'b0, 32'h110,        32'h0,        32'hDEADBEEF});
    vecs.push_back('{1'b0, 32'h4000_0010,  32'h0,        32'hDEADBEEF});
    vecs.push_back('{1'b0, 32'h8000_0010,  32'h0,        32'h0});
    vecs.push_back('{1'b0, 32'hFFFF_0008,  32'h0,        32'h0});
    vecs.push_back('{1'b1, 32'hFFFF_0008,  32'h000000AB, 32'h0});
    vecs.push_back('{1'b0, 32'h08,         32'h0,        32'h11111111});
    vecs.push_back('{1'b0, STATUS,         32'h0,        32'h0000_0002});
    vecs.push_back('{1'b0, 32'hFFFF_000C,  32'h0,        32'h0});

    reset = 1'b1;
    repeat (3) tick();
    chk("reset_tx", {31'd0, tx}, 32'd1);
    chk("reset_tx_busy", {31'd0, tx_busy}, 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].we) begin
        wr(vecs[i].a, vecs[i].d);
      end else begin
        addr = vecs[i].a;
        #1;
        chk($sformatf("vec%0d", i), readdata, vecs[i].req);
      end
    end
    chk("unmapped_no_busy", {31'd0, tx_busy}, 32'd0);

    // Single frame of 0x55 with exact waveform.
    txw(8'h55, 1'b1);
    chk("single_busy_after_push", {31'd0, tx_busy}, 32'd1);
    status_chk("single_status_push", 32'h0000_0010);
    tick();
    status_chk("single_status_start", 32'h0000_0006);
    errs = 0;
    first_bad = -1;
    for (int i = 0; i < 10 * CPB; i++) begin
      if (i / CPB == 0)      req_tx = 1'b0;
      else if (i / CPB == 9) req_tx = 1'b1;
      else                   req_tx = (8'h55 >> (i / CPB - 1)) & 1'b1;
      if (tx !== req_tx || tx_busy !== 1'b1) begin
        errs++;
        if (first_bad < 0) first_bad = i;
      end
      tick();
    end
    chk($sformatf("single_wave_errs_first%0d", first_bad), errs, 32'd0);
    chk("single_busy_drop_161", {31'd0, tx_busy}, 32'd0);
    chk("single_idle_tx", {31'd0, tx}, 32'd1);
    drain("single");

    // Back-to-back burst, overflow, overflow clear.
    starts.delete();
    txw(8'hA1, 1'b1);
    txw(8'h5E, 1'b1);
    txw(8'hFF, 1'b1);
    txw(8'h00, 1'b1);
    txw(8'h81, 1'b1);
    status_chk("burst_full", 32'h0000_0045);
    txw(8'hEE, 1'b0);
    status_chk("burst_overflow", 32'h0000_004D);
    wr(STATUS, 32'h1234_5678);
    status_chk("burst_ovf_clear", 32'h0000_0045);
    drain("burst");
    gap_chk("burst", 5);

    // Push on the same edge the full FIFO pops.
    starts.delete();
    txw(8'h10, 1'b1);
    txw(8'h32, 1'b1);
    txw(8'h54, 1'b1);
    txw(8'h76, 1'b1);
    txw(8'h98, 1'b1);
    addr = STATUS;
    n = 0;
    do begin
      tick();
      n++;
    end while (readdata[2] !== 1'b0 && n < 400);
    chk("simul_idle_reached", {31'd0, (n < 400)}, 32'd1);
    chk("simul_status_idle_full", readdata, 32'h0000_0041);
    txw(8'hC3, 1'b1);
    status_chk("simul_status_after", 32'h0000_0045);
    drain("simul");
    gap_chk("simul", 6);

    // Reset during data bit 3, with a TXDATA write in the reset cycle.
    txw(8'hA5, 1'b1);
    repeat (1 + CPB + 3 * CPB + CPB / 2) tick();
    chk("rst_mid_bit3", {31'd0, tx}, 32'd0);
    reset     = 1'b1;
    memwrite  = 1'b1;
    addr      = TXDATA;
    writedata = 32'h77;
    tick();
    memwrite  = 1'b0;
    chk("rst_tx_high", {31'd0, tx}, 32'd1);
    chk("rst_busy_low", {31'd0, tx_busy}, 32'd0);
    status_chk("rst_status", 32'h0000_0002);
    reset = 1'b0;
    tick();
    status_chk("rst_write_ignored", 32'h0000_0002);
    txw(8'h3C, 1'b1);
    drain("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_uart.md
# dmem_uart

Data-side memory system for the single-cycle MIPS core. Sits directly downstream of the core's `memwrite`/`aluout`/`writedata` outputs and drives its `readdata` input. It provides:

- a word-addressed data RAM;
- a memory-mapped UART transmitter with a small TX FIFO and an 8N1 serializer.

Reads are combinational so the core completes loads in one cycle; all state updates occur on the clock edge.

## Interface

Parameters:

- `RAM_WORDS`, 64, data RAM depth in 32-bit words (power of 2, 16..1024)
- `CLKS_PER_BIT`, 16, clock cycles per UART bit (>= 2)
- `FIFO_DEPTH`, 4, TX FIFO entries (2 or 4)

Ports:

- `clk`  in  1  system clock; all state changes on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `memwrite`  in  1  store strobe from the core
- `addr`  in  32  byte address (the core's `aluout`)
- `writedata`  in  32  store data
- `readdata`  out  32  load data, combinational from `addr`
- `tx`  out  1  UART serial output, registered, idle high
- `tx_busy`  out  1  high when the FIFO is non-empty or the serializer is not IDLE

## Operation

Address decode:

- `addr[31]==0` selects RAM.
  - Word index is `addr[log2(RAM_WORDS)+1:2]`; upper bits and `addr[1:0]` are ignored (aliasing).
  - Writes happen on the edge when `memwrite==1`.
  - Reads are asynchronous.
- `addr==0xFFFF0000` is TXDATA.
  - A write pushes `writedata[7:0]`.
  - A read returns 0.
- `addr==0xFFFF0004` is STATUS.
  - A read returns `{25'b0, count[2:0], overflow, busy, empty, full}`, where bit0 = `full` and bits 6:4 = `count`.
  - `busy` means the serializer state is not IDLE.
  - A write (any data) clears `overflow`.
- Any other address with `addr[31]==1`: reads return 0 and writes are ignored.
- RAM contents are not reset.

FIFO:

- Push happens on a TXDATA write. Pop happens when the serializer leaves IDLE.
- A push is accepted if `count < FIFO_DEPTH`, or if a pop occurs in the same cycle.
- Otherwise the byte is dropped and the sticky `overflow` bit is set.
- Simultaneous push and pop leaves `count` unchanged and preserves FIFO order.
- Pointers wrap modulo `FIFO_DEPTH`.

Serializer state machine (IDLE, START, DATA, STOP):

- **IDLE:** `tx=1`. If the FIFO is non-empty, pop the head into the shift register and go to START.
- **START:** `tx=0` for `CLKS_PER_BIT` cycles, then go to DATA.
- **DATA:** shift 8 bits out LSB first, each for `CLKS_PER_BIT` cycles. A bit counter runs 0..7; after bit 7, go to STOP.
- **STOP:** `tx=1` for `CLKS_PER_BIT` cycles, then go to IDLE.
- A frame is 10 bit-times. Back-to-back frames are separated by exactly one IDLE cycle.

Reset:

- Effects:
  - FIFO is emptied;
  - `overflow` is cleared;
  - state goes to IDLE;
  - `tx=1`;
  - `tx_busy=0`;
  - bit and baud counters are cleared.
- `readdata` depends only on `addr` and state.
- Reset asserted mid-frame aborts the frame: `tx` is 1 on the cycle after the reset edge, and the aborted byte is lost.
- A TXDATA write in a reset cycle is ignored.

## Timing

- Load latency is 0 cycles (combinational).
- Store to RAM: visible to a read in the cycle after the write edge.
- TXDATA write at edge N with the serializer IDLE and the FIFO empty:
  - `count` becomes 1 after edge N;
  - the pop occurs at edge N+1;
  - `tx` falls after edge N+1 (START begins);
  - data bit 0 appears `CLKS_PER_BIT` cycles later.
- `tx` is driven from a flop; it never glitches.
- `tx_busy` is high from the edge that pushes the first byte until the edge that returns to IDLE with the FIFO empty.
- STATUS reflects post-edge state. A push at edge N is visible in `count` in cycle N+1.

## Test plan

- **RAM word and aliasing:** write 0xDEADBEEF to 0x00000010, then read 0x00000010 and 0x00000013 → both 0xDEADBEEF. Read 0x00000014 → unaffected by the write.
- **Single frame:** write 0x55 to TXDATA with `CLKS_PER_BIT=16`. Required:
  - `tx` low for 16 cycles;
  - then bits 1,0,1,0,1,0,1,0, each 16 cycles;
  - then high for 16 cycles;
  - `tx_busy` drops after 161 cycles (1 IDLE pop cycle + 10 bit-times of 16 cycles).
- **Back-to-back and full:** write 5 bytes in consecutive cycles with `FIFO_DEPTH=4`. Required:
  - the first byte is popped at the next edge, so all 5 are accepted and `overflow` stays 0;
  - `count` peaks at 4 and `full` is 1;
  - a 6th write while full with no pop → dropped and `overflow` set;
  - a STATUS write clears `overflow`;
  - frames are separated by 1 idle cycle.
- **Simultaneous push/pop when full:** hold the FIFO full, then issue a push in the cycle the serializer leaves IDLE → byte accepted, `count` stays 4, `overflow` stays 0.
- **Reset mid-frame:** assert `reset` during DATA bit 3 → after the next edge `tx=1`, `tx_busy=0`, STATUS=0x00000002. A new write afterwards transmits normally.
- **Unmapped I/O:** read 0xFFFF0008 → 0. A write there leaves RAM and FIFO unchanged.
